// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for a small bus-based CPU.
// Walks each instruction through fetch (T0-T2) and execute (T3-T5) steps
// and decodes the bus strobes as Moore outputs of the current step and the
// opcode held in ir[31:27].
//
// Handshake: there is no valid/ready pair; the only request input is stop,
// which is sampled solely on the clock edge that ends an instruction
// (end of T3 for JR/NOP, end of T5 for ALU ops and LDI).
module control_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      ir,
    input  logic             stop,
    output logic             PCout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             Cout,
    output logic             PCin,
    output logic             MARin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             IncPC,
    output logic             MDRRead,
    output logic             RAMread,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin_in,
    output logic             Rout_in,
    output logic             BAout,
    output logic [11:0]      ALUControl,
    output logic             run,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_T0    = 3'd1,
        S_T1    = 3'd2,
        S_T2    = 3'd3,
        S_T3    = 3'd4,
        S_T4    = 3'd5,
        S_T5    = 3'd6,
        S_HALT  = 3'd7
    } state_t;

    state_t state;
    state_t next_state;

    logic [4:0] opcode;
    logic       is_alu;
    logic       is_ldi;
    logic       is_jr;
    logic       is_halt;
    logic       unused_ir_bits;

    // Only the opcode field steers the sequencer; register fields go elsewhere.
    assign opcode         = ir[31:27];
    assign unused_ir_bits = ^ir[26:0];
    assign is_alu         = (opcode[4:2] == 3'b000);
    assign is_ldi         = (opcode == 5'b00100);
    assign is_jr          = (opcode == 5'b00101);
    assign is_halt        = (opcode == 5'b00111);

    assign state_dbg = state;

    // State register; clr drops the sequencer back to RESET at once.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Retired-instruction counter: bumps as IR is loaded at the end of T2.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            instr_count <= '0;
        end else if (state == S_T2) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Next-state and strobe decode; everything defaults to idle.
    always_comb begin
        next_state = state;
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        MDRout     = 1'b0;
        Cout       = 1'b0;
        PCin       = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        IncPC      = 1'b0;
        MDRRead    = 1'b0;
        RAMread    = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin_in     = 1'b0;
        Rout_in    = 1'b0;
        BAout      = 1'b0;
        ALUControl = 12'h000;
        run        = 1'b1;

        case (state)
            S_RESET: begin
                run        = 1'b0;
                next_state = S_T0;
            end
            S_T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                Zin        = 1'b1;
                next_state = S_T1;
            end
            S_T1: begin
                Zlowout    = 1'b1;
                PCin       = 1'b1;
                MDRRead    = 1'b1;
                MDRin      = 1'b1;
                RAMread    = 1'b1;
                next_state = S_T2;
            end
            S_T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                next_state = S_T3;
            end
            S_T3: begin
                if (is_alu) begin
                    Grb        = 1'b1;
                    Rout_in    = 1'b1;
                    Yin        = 1'b1;
                    next_state = S_T4;
                end else if (is_ldi) begin
                    Grb        = 1'b1;
                    BAout      = 1'b1;
                    Yin        = 1'b1;
                    next_state = S_T4;
                end else if (is_jr) begin
                    Gra        = 1'b1;
                    Rout_in    = 1'b1;
                    PCin       = 1'b1;
                    next_state = stop ? S_HALT : S_T0;
                end else if (is_halt) begin
                    next_state = S_HALT;
                end else begin
                    // NOP and every unassigned opcode end here quietly.
                    next_state = stop ? S_HALT : S_T0;
                end
            end
            S_T4: begin
                Zin = 1'b1;
                if (is_alu) begin
                    Grc     = 1'b1;
                    Rout_in = 1'b1;
                    case (opcode[1:0])
                        2'b00:   ALUControl = 12'h001;
                        2'b01:   ALUControl = 12'h002;
                        2'b10:   ALUControl = 12'h004;
                        default: ALUControl = 12'h008;
                    endcase
                end else begin
                    // LDI: base register (or 0) plus the constant field.
                    Cout       = 1'b1;
                    ALUControl = 12'h001;
                end
                next_state = S_T5;
            end
            S_T5: begin
                Zlowout    = 1'b1;
                Gra        = 1'b1;
                Rin_in     = 1'b1;
                next_state = stop ? S_HALT : S_T0;
            end
            S_HALT: begin
                run        = 1'b0;
                next_state = S_HALT;
            end
            default: begin
                run        = 1'b0;
                next_state = S_RESET;
            end
        endcase
    end

endmodule
